// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU/loader request ports and RAM port of the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_lock;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU and loader with lock and anti-starvation
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    owner_t            owner, owner_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [1:0]        rd_pend;
    logic              locked;
    logic              cpu_win, ldr_win;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            rd_pend    <= '0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            rd_pend    <= {ldr_win & ~bus.ldr_we, cpu_win & ~bus.cpu_we};
        end
    end

    always_comb begin
        cpu_win    = 1'b0;
        ldr_win    = 1'b0;
        owner_nxt  = owner;
        starve_nxt = starve_cnt;
        locked     = (owner == OWN_CPU) && bus.cpu_lock;

        // Grants are gated by reset so nothing reaches the RAM while held in reset
        if (!rst_n) begin
            cpu_win = 1'b0;
        end else if (locked) begin
            cpu_win = bus.cpu_req;
        end else if (bus.cpu_req && bus.ldr_req) begin
            if (starve_cnt == HOLD_LIMIT) cpu_win = 1'b1;
            else                          ldr_win = 1'b1;
        end else begin
            cpu_win = bus.cpu_req;
            ldr_win = bus.ldr_req;
        end

        if (cpu_win)                                    owner_nxt = OWN_CPU;
        else if (ldr_win)                               owner_nxt = OWN_LDR;
        else if (owner == OWN_CPU && !bus.cpu_lock)     owner_nxt = OWN_NONE;

        if (cpu_win || !bus.cpu_req)                    starve_nxt = '0;
        else if (ldr_win && starve_cnt != HOLD_LIMIT)   starve_nxt = starve_cnt + 4'd1;
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (cpu_win) begin
            we_sel    = bus.cpu_we;
            addr_sel  = bus.cpu_addr;
            wdata_sel = bus.cpu_wdata;
        end else if (ldr_win) begin
            we_sel    = bus.ldr_we;
            addr_sel  = bus.ldr_addr;
            wdata_sel = bus.ldr_wdata;
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.ldr_gnt    = ldr_win;
    assign bus.mem_en     = cpu_win | ldr_win;
    assign bus.mem_we     = we_sel;
    assign bus.mem_addr   = addr_sel;
    assign bus.mem_wdata  = wdata_sel;

    // RAM output is shared; the rvalid bits say whose read it is
    assign bus.cpu_rvalid = rd_pend[0];
    assign bus.ldr_rvalid = rd_pend[1];
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.ldr_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and random checks of mem_arbiter against a cycle-level reference model
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM macro stand-in: synchronous read, one cycle latency
    logic [DW-1:0] ram    [0:255];
    logic [DW-1:0] shadow [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    // Reference model: last winner, CPU wait length, and expected read returns
    int            m_last = 0;   // 0 none, 1 cpu, 2 loader
    int            m_wait = 0;
    bit            m_cpu_rv = 0, m_ldr_rv = 0;
    logic [DW-1:0] m_cpu_rd = '0, m_ldr_rd = '0;

    int total = 0;
    int bad   = 0;

    bit            obs_cg, obs_lg, obs_crv, obs_lrv;
    logic [DW-1:0] obs_crd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r,
                         input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd, input bit cl,
                         input bit lr, input bit lw, input logic [7:0] la, input logic [7:0] ld,
                         input bit late_rst = 1'b0);
        bit ec, el;
        bit ewe;
        logic [7:0] ea, ed;
        rst_n         = r;
        bus.cpu_req   = cr;  bus.cpu_we = cw;  bus.cpu_addr = ca;  bus.cpu_wdata = cd;  bus.cpu_lock = cl;
        bus.ldr_req   = lr;  bus.ldr_we = lw;  bus.ldr_addr = la;  bus.ldr_wdata = ld;
        #1;
        ec = 1'b0; el = 1'b0;
        if (r) begin
            if (m_last == 1 && cl)   ec = cr;
            else if (cr && lr) begin
                if (m_wait >= MH) ec = 1'b1;
                else              el = 1'b1;
            end else begin
                ec = cr; el = lr;
            end
        end
        ewe = ec ? cw : (el ? lw : 1'b0);
        ea  = ec ? ca : (el ? la : 8'h00);
        ed  = ec ? cd : (el ? ld : 8'h00);
        chk("cpu_gnt",   32'(bus.cpu_gnt),   32'(ec));
        chk("ldr_gnt",   32'(bus.ldr_gnt),   32'(el));
        chk("mem_en",    32'(bus.mem_en),    32'(ec | el));
        chk("mem_we",    32'(bus.mem_we),    32'(ewe));
        chk("mem_addr",  32'(bus.mem_addr),  32'(ea));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_cpu_rv));
        chk("ldr_rvalid", 32'(bus.ldr_rvalid), 32'(m_ldr_rv));
        if (m_cpu_rv) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu_rd));
        if (m_ldr_rv) chk("ldr_rdata", 32'(bus.ldr_rdata), 32'(m_ldr_rd));
        obs_cg  = bus.cpu_gnt;
        obs_lg  = bus.ldr_gnt;
        obs_crv = bus.cpu_rvalid;
        obs_lrv = bus.ldr_rvalid;
        obs_crd = bus.cpu_rdata;
        if (late_rst) begin
            #1 rst_n = 1'b0;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_last = 0; m_wait = 0; m_cpu_rv = 0; m_ldr_rv = 0;
        end else begin
            m_cpu_rv = ec && !cw;
            m_ldr_rv = el && !lw;
            if (m_cpu_rv) m_cpu_rd = shadow[ca];
            if (m_ldr_rv) m_ldr_rd = shadow[la];
            if (ec && cw) shadow[ca] = cd;
            if (el && lw) shadow[la] = ld;
            if (ec) begin
                m_last = 1; m_wait = 0;
            end else if (el) begin
                m_last = 2;
                m_wait = cr ? ((m_wait + 1 > MH) ? MH : m_wait + 1) : 0;
            end else begin
                if (m_last == 1 && !cl) m_last = 0;
                if (!cr) m_wait = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input bit r);
        cycle(r, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        bit rl;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'((i * 37) + 11);
            shadow[i] = 8'((i * 37) + 11);
        end
        ram[8'h0F]    = 8'h3C;
        shadow[8'h0F] = 8'h3C;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_lock = 0;
        bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        @(posedge clk);
        #1;

        // Reset with both requesting, then release into continuous contention
        cycle(0, 1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h02, 8'h00);
        chk("t1_rst_mem_en", 32'(obs_cg | obs_lg), 32'd0);
        cycle(0, 1, 0, 8'h01, 8'h00, 0, 1, 0, 8'h02, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 0, 8'(i), 8'h00, 0, 1, 0, 8'(i + 100), 8'h00);
            chk("t3_pattern_ldr", 32'(obs_lg), 32'((i % 5) != 4));
            chk("t3_pattern_cpu", 32'(obs_cg), 32'((i % 5) == 4));
        end
        idle(1);

        // CPU read of a preloaded location
        cycle(1, 1, 0, 8'h0F, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        chk("t2_cpu_gnt", 32'(obs_cg), 32'd1);
        idle(1);
        chk("t2_cpu_rvalid", 32'(obs_crv), 32'd1);
        chk("t2_cpu_rdata", 32'(obs_crd), 32'h3C);
        idle(1);

        // Lock holds the RAM for the CPU while it is idle
        cycle(1, 1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        chk("t4_lock_gnt", 32'(obs_cg), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h05, 8'h00);
            chk("t4_locked_ldr", 32'(obs_lg), 32'd0);
        end
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h05, 8'h00);
        chk("t4_unlock_ldr", 32'(obs_lg), 32'd1);
        idle(1);

        // Loader write then CPU readback
        cycle(1, 0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h20, 8'hA5);
        cycle(1, 1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        chk("t5_no_wr_rvalid", 32'(obs_lrv | obs_crv), 32'd0);
        idle(1);
        chk("t5_cpu_rdata", 32'(obs_crd), 32'hA5);
        idle(1);

        // Reset right behind a granted read
        cycle(1, 1, 0, 8'h30, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1'b1);
        chk("t6_gnt_before_rst", 32'(obs_cg), 32'd1);
        idle(0);
        chk("t6_rvalid_dropped", 32'(obs_crv), 32'd0);
        idle(1);
        chk("t6_no_stale_gnt", 32'(obs_cg | obs_lg), 32'd0);
        cycle(1, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h07, 8'h00);
        chk("t6_lock_no_owner", 32'(obs_lg), 32'd1);

        // Random traffic
        rl = 0;
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 8) == 0) rl = ~rl;
            cycle((($urandom % 64) != 0),
                  1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), rl,
                  1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
